// File: rtl/serial_cla_subtractor_pkg.sv
// Shared definitions for the nibble-serial carry-look-ahead subtractor.
package serial_cla_subtractor_pkg;

  // Width of one carry-look-ahead slice; the operands are walked one slice per cycle.
  localparam int NIBBLE_W = 4;

  // Control states of the serial subtractor.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_cla_subtractor_cla4_slice.sv
// Four-bit carry-look-ahead adder slice: every carry is formed directly from
// generate/propagate terms rather than rippling through the previous bit.
module cla4_slice (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  // Flattened look-ahead equations for the internal carries and the carry-out.
  always_comb begin
    g    = x & y;
    p    = x ^ y;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    sum  = p ^ c[3:0];
    cout = c[4];
  end

endmodule

// File: rtl/serial_cla_subtractor.sv
// Nibble-serial subtractor: computes a - b - bin as a + ~b + ~bin, one
// four-bit slice per cycle starting at the least significant nibble, reusing
// a single carry-look-ahead slice with the carry held in a register between cycles.
module serial_cla_subtractor
  import serial_cla_subtractor_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST_NIB = CW'(NIBBLES - 1);
  localparam int MSB     = WIDTH - 1;

  state_t               state;
  state_t               state_nxt;
  logic [CW-1:0]        nib_idx;
  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     b_q;
  logic [WIDTH-1:0]     diff_q;
  logic                 carry_q;
  logic                 bout_q;
  logic                 ovf_q;
  logic [NIBBLE_W-1:0]  x_nib;
  logic [NIBBLE_W-1:0]  y_nib;
  logic [NIBBLE_W-1:0]  sum_nib;
  logic                 slice_cout;
  logic                 accept;
  logic                 last_nib;

  // A new operation is taken only when nothing is in flight; start during RUN is dropped.
  always_comb begin
    accept   = ((state == IDLE) || (state == DONE)) && start;
    last_nib = (nib_idx == LAST_NIB);
    x_nib    = a_q[nib_idx*NIBBLE_W +: NIBBLE_W];
    y_nib    = ~b_q[nib_idx*NIBBLE_W +: NIBBLE_W];
  end

  cla4_slice u_slice (
    .x    (x_nib),
    .y    (y_nib),
    .cin  (carry_q),
    .sum  (sum_nib),
    .cout (slice_cout)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: RUN lasts exactly one cycle per nibble, DONE lasts one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_nib) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs decode directly from the state.
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Datapath: latch operands on accept, then build the result one nibble per RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      carry_q <= 1'b0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      nib_idx <= '0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b;
      carry_q <= ~bin;
      nib_idx <= '0;
    end else if (state == RUN) begin
      diff_q[nib_idx*NIBBLE_W +: NIBBLE_W] <= sum_nib;
      carry_q <= slice_cout;
      nib_idx <= nib_idx + 1'b1;
      if (last_nib) begin
        bout_q <= ~slice_cout;
        ovf_q  <= (a_q[MSB] != b_q[MSB]) && (sum_nib[NIBBLE_W-1] != a_q[MSB]);
      end
    end
  end

  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_cla_subtractor.sv
// Directed and randomised bench for the nibble-serial subtractor at WIDTH=16.
module tb_serial_cla_subtractor;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        bin;
  logic [15:0] diff;
  logic        bout;
  logic        ovf;
  logic        busy;
  logic        done;

  int total;
  int bad;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] expDiff;
    logic        expBout;
    logic        expOvf;
  } vec_t;

  vec_t vecs[10];

  serial_cla_subtractor #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .diff  (diff),
    .bout  (bout),
    .ovf   (ovf),
    .busy  (busy),
    .done  (done)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value with its expected value and tally the result.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one operation from a negedge and wait (bounded) for done; returns negedges waited.
  task automatic applyStimulus(input logic [15:0] va, input logic [15:0] vb, input logic vbin,
                               output int cycles);
    start = 1'b1;
    a     = va;
    b     = vb;
    bin   = vbin;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = 16'($urandom);
    b     = 16'($urandom);
    bin   = 1'($urandom);
    cycles = 0;
    while (cycles < 20) begin
      @(negedge clk);
      cycles++;
      if (done) break;
    end
  endtask

  // Independent arithmetic reference: widened subtraction gives the borrow directly.
  task automatic model(input logic [15:0] va, input logic [15:0] vb, input logic vbin,
                       output logic [15:0] md, output logic mbo, output logic mov);
    logic [16:0] r;
    r   = {1'b0, va} - {1'b0, vb} - {16'b0, vbin};
    md  = r[15:0];
    mbo = r[16];
    mov = (va[15] != vb[15]) && (r[15] != va[15]);
  endtask

  initial begin
    int          cyc;
    int          doneCount;
    logic [15:0] md;
    logic        mbo;
    logic        mov;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rbin;

    total = 0;
    bad   = 0;

    vecs[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vecs[2] = '{16'h00FF, 16'h00FF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[3] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
    vecs[4] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[6] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[7] = '{16'hABCD, 16'h1234, 1'b0, 16'h9999, 1'b0, 1'b0};
    vecs[8] = '{16'h8000, 16'h7FFF, 1'b0, 16'h0001, 1'b0, 1'b1};
    vecs[9] = '{16'h1000, 16'h0FFF, 1'b1, 16'h0000, 1'b0, 1'b0};

    rst   = 1'b1;
    start = 1'b1;
    a     = 16'h5555;
    b     = 16'h1111;
    bin   = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset diff", 32'(diff), 32'h0);
    checkOutput("reset bout", 32'(bout), 32'h0);
    checkOutput("reset ovf",  32'(ovf),  32'h0);
    checkOutput("reset busy", 32'(busy), 32'h0);
    checkOutput("reset done", 32'(done), 32'h0);
    start = 1'b0;
    rst   = 1'b0;
    @(negedge clk);
    checkOutput("idle busy", 32'(busy), 32'h0);

    $display("[TB] directed vector table");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].bin, cyc);
      checkOutput($sformatf("vec%0d latency", i), 32'(cyc), 32'd5);
      checkOutput($sformatf("vec%0d diff", i), 32'(diff), 32'(vecs[i].expDiff));
      checkOutput($sformatf("vec%0d bout", i), 32'(bout), 32'(vecs[i].expBout));
      checkOutput($sformatf("vec%0d ovf", i),  32'(ovf),  32'(vecs[i].expOvf));
      checkOutput($sformatf("vec%0d busy", i), 32'(busy), 32'h0);
    end
    @(negedge clk);
    checkOutput("done one cycle", 32'(done), 32'h0);
    checkOutput("hold diff", 32'(diff), 32'h0000);

    $display("[TB] start while busy is ignored");
    start = 1'b1;
    a     = 16'h1234;
    b     = 16'h0234;
    bin   = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    checkOutput("run busy", 32'(busy), 32'h1);
    @(negedge clk);
    start = 1'b1;
    a     = 16'hFFFF;
    b     = 16'h0001;
    bin   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 2;
    while (cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (done) break;
    end
    checkOutput("ignored start latency", 32'(cyc), 32'd5);
    checkOutput("ignored start diff", 32'(diff), 32'h1000);
    checkOutput("ignored start bout", 32'(bout), 32'h0);
    applyStimulus(16'h8000, 16'h0001, 1'b0, cyc);
    checkOutput("back-to-back latency", 32'(cyc), 32'd5);
    checkOutput("back-to-back diff", 32'(diff), 32'h7FFF);
    checkOutput("back-to-back ovf",  32'(ovf),  32'h1);
    @(negedge clk);

    $display("[TB] reset during RUN");
    start = 1'b1;
    a     = 16'h4321;
    b     = 16'h0123;
    bin   = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort diff", 32'(diff), 32'h0);
    checkOutput("abort bout", 32'(bout), 32'h0);
    checkOutput("abort ovf",  32'(ovf),  32'h0);
    checkOutput("abort busy", 32'(busy), 32'h0);
    checkOutput("abort done", 32'(done), 32'h0);
    rst = 1'b0;
    doneCount = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) doneCount++;
    end
    checkOutput("abort no done", 32'(doneCount), 32'd0);
    applyStimulus(16'h4321, 16'h0123, 1'b1, cyc);
    checkOutput("post-reset latency", 32'(cyc), 32'd5);
    checkOutput("post-reset diff", 32'(diff), 32'h41FD);
    checkOutput("post-reset bout", 32'(bout), 32'h0);

    $display("[TB] random operations");
    for (int n = 0; n < 10000; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        @(negedge clk);
        checkOutput("random done pulse", 32'(done), 32'h0);
      end
      ra   = 16'($urandom);
      rb   = 16'($urandom);
      rbin = 1'($urandom);
      if ($urandom_range(0, 7) == 0) rb = ra;
      model(ra, rb, rbin, md, mbo, mov);
      applyStimulus(ra, rb, rbin, cyc);
      checkOutput("random latency", 32'(cyc), 32'd5);
      checkOutput("random diff", 32'(diff), 32'(md));
      checkOutput("random bout", 32'(bout), 32'(mbo));
      checkOutput("random ovf",  32'(ovf),  32'(mov));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_cla_subtractor.md
SERIAL_CLA_SUBTRACTOR -- requirements
Module: serial_cla_subtractor

Interface
REQ-001 Parameter: WIDTH, 16, operand width in bits; SHALL be a multiple of 4 and at least 8.
REQ-002 Port: clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: start  input  1  request a new subtraction; sampled only when the block can accept it.
REQ-005 Port: a  input  WIDTH  minuend; sampled on the accepting edge only.
REQ-006 Port: b  input  WIDTH  subtrahend; sampled on the accepting edge only.
REQ-007 Port: bin  input  1  borrow-in; sampled on the accepting edge only.
REQ-008 Port: diff  output  WIDTH  result a - b - bin, modulo 2^WIDTH.
REQ-009 Port: bout  output  1  borrow-out; 1 when a < b + bin, unsigned.
REQ-010 Port: ovf  output  1  two's-complement signed overflow of the subtraction.
REQ-011 Port: busy  output  1  high while a subtraction is in progress.
REQ-012 Port: done  output  1  one-cycle pulse: diff, bout and ovf are valid.

Function
REQ-013 The block SHALL compute a + ~b + ~bin, one 4-bit nibble per cycle, LSB nibble first, using a single 4-bit carry-look-ahead slice.
REQ-014 State machine: IDLE, RUN, DONE.
- IDLE -> RUN on start=1.
- RUN -> DONE after the last nibble.
- DONE -> RUN on start=1.
- DONE -> IDLE otherwise.
REQ-015 Accepting edge: an edge where state is IDLE or DONE and start=1. On that edge the block SHALL latch a, b and ~bin (the initial carry), and clear the nibble counter.
REQ-016 In RUN, each edge SHALL write nibble k of diff from the slice sum, register the slice carry-out as the next carry-in, and increment k.
REQ-017 After the edge that writes nibble WIDTH/4-1, the state SHALL be DONE.
REQ-018 Latency: done=1 in the cycle following WIDTH/4 RUN cycles, i.e. WIDTH/4+1 edges after the accepting edge; 5 edges for WIDTH=16.
REQ-019 busy SHALL be 1 exactly while the state is RUN. done SHALL be 1 exactly while the state is DONE.
REQ-020 bout SHALL equal the inverted final carry-out.
REQ-021 ovf SHALL equal (a[MSB] != b[MSB]) and (diff[MSB] != a[MSB]), using the latched operands.
REQ-022 diff, bout and ovf SHALL hold their values from DONE until the next accepting edge. During RUN, diff is undefined to the consumer.
REQ-023 start while busy=1 SHALL be ignored; no queuing and no effect on the operation in progress.
REQ-024 start=1 during the DONE cycle SHALL be accepted: back-to-back operation, done pulses one period apart.
REQ-025 Changes on a, b or bin after the accepting edge SHALL NOT affect the result.

Reset
REQ-026 rst=1 at an edge SHALL force:
- state IDLE;
- diff=0, bout=0, ovf=0, busy=0, done=0;
- counter and carry cleared.
REQ-027 Reset SHALL take priority over start.
REQ-028 Reset during RUN or DONE SHALL abandon the operation with no done pulse.
REQ-029 The first accepting edge is the first edge with rst=0 and start=1.

Structure
REQ-030 A shared package SHALL hold:
- the state enumeration (IDLE, RUN, DONE);
- the nibble width constant (4).
REQ-031 Sub-module: cla4_slice. Ports: 4-bit x, y, carry-in; 4-bit sum, carry-out. Purely combinational generate/propagate look-ahead, instantiated once.
REQ-032 Operand shifting or nibble muxing, counter and FSM SHALL reside in serial_cla_subtractor. No other sub-modules.

Verification (WIDTH=16)
REQ-033 a=0x1234, b=0x0234, bin=0 -> done 5 edges after accept; diff=0x1000, bout=0, ovf=0.
REQ-034 a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1, ovf=0. Also a=0x00FF, b=0x00FF, bin=1 -> diff=0xFFFF, bout=1.
REQ-035 a=0x8000, b=0x0001, bin=0 -> diff=0x7FFF, bout=0, ovf=1. Also a=0x7FFF, b=0xFFFF -> diff=0x8000, bout=1, ovf=1.
REQ-036 Pulse start with new operands while busy=1 -> result is that of the first operation; no extra done. Then start in the DONE cycle -> second done exactly 5 cycles later.
REQ-037 Assert rst at the 2nd RUN edge -> next cycle all outputs 0, state IDLE, no done pulse. A fresh start afterwards yields a correct result.
REQ-038 Random 10k operations, including back-to-back starts, checked against a reference model of a-b-bin (diff, bout, ovf).
